// File: rtl/mcoi_buffer_regbank_pkg.sv
// Shared definitions for the MCOI buffer-port register bank: clock/reset
// record, register word indices and byte-lane merge helpers.
package mcoi_buffer_regbank_pkg;

  localparam int          NUM_MOTORS       = 16;
  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4D43_4F49;
  localparam int          REG_IDX_W        = 6;

  // Register word indices (byte address = index << ADDR_LSB)
  localparam logic [REG_IDX_W-1:0] IDX_ID           = 6'd0;
  localparam logic [REG_IDX_W-1:0] IDX_EN           = 6'd1;
  localparam logic [REG_IDX_W-1:0] IDX_BOOST        = 6'd2;
  localparam logic [REG_IDX_W-1:0] IDX_PFAIL        = 6'd3;
  localparam logic [REG_IDX_W-1:0] IDX_PFAIL_STICKY = 6'd4;
  localparam logic [REG_IDX_W-1:0] IDX_IRQ_MASK     = 6'd5;
  localparam logic [REG_IDX_W-1:0] IDX_SW_A         = 6'd6;
  localparam logic [REG_IDX_W-1:0] IDX_SW_B         = 6'd7;
  localparam logic [REG_IDX_W-1:0] IDX_SCRATCH      = 6'd8;

  typedef enum logic [REG_IDX_W-1:0] {
    REG_ID           = IDX_ID,
    REG_EN           = IDX_EN,
    REG_BOOST        = IDX_BOOST,
    REG_PFAIL        = IDX_PFAIL,
    REG_PFAIL_STICKY = IDX_PFAIL_STICKY,
    REG_IRQ_MASK     = IDX_IRQ_MASK,
    REG_SW_A         = IDX_SW_A,
    REG_SW_B         = IDX_SW_B,
    REG_SCRATCH      = IDX_SCRATCH
  } regbank_addr_t;

  // Clock/reset record carried on the buffer port
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  // Replace the bytes of a 32-bit word selected by the byte enables
  function automatic logic [31:0] byte_merge32(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // Same for the 16-bit registers, which only see the two low lanes
  function automatic logic [15:0] byte_merge16(input logic [15:0] cur,
                                               input logic [15:0] wdata,
                                               input logic [1:0]  be);
    logic [15:0] res;
    res = cur;
    for (int i = 0; i < 2; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // Write-one-to-clear mask restricted to the enabled byte lanes
  function automatic logic [15:0] w1c_mask16(input logic [15:0] wdata,
                                             input logic [1:0]  be);
    return wdata & {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/mcoi_buffer_regbank_sync.sv
// Multi-bit, multi-stage synchroniser for quasi-static asynchronous status
// inputs. Each bit is synchronised independently; bits are not coherent.
module mcoi_sync_vector #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  // Shift the chain by one stage per clock, new sample enters at stage 0
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  // Synchroniser flops, cleared by the asynchronous reset
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value and the chain really shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/mcoi_buffer_regbank.sv
// MCOI buffer-port register bank: motor enable/boost control, synchronised
// fault and end-switch status, sticky fault capture with masked interrupt.
module mcoi_buffer_regbank
  import mcoi_buffer_regbank_pkg::*;
#(
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT,
  parameter int          SYNC_STAGES = 2,
  parameter int          ADDR_LSB    = 2
) (
  input  ckrs_t                  ClkRs_ix,
  input  logic                   en,
  input  logic [3:0]             we,
  input  logic [31:0]            addr,
  input  logic [31:0]            din,
  input  logic                   rst,
  output logic [31:0]            dout,
  input  logic [NUM_MOTORS-1:0]  pl_pfail,
  input  logic [NUM_MOTORS-1:0]  pl_sw_outa,
  input  logic [NUM_MOTORS-1:0]  pl_sw_outb,
  output logic [NUM_MOTORS-1:0]  motor_en,
  output logic [NUM_MOTORS-1:0]  motor_boost,
  output logic                   irq
);

  logic clk;
  logic reset;
  assign clk   = ClkRs_ix.clk;
  assign reset = ClkRs_ix.reset;

  // Only a 6-bit word index is decoded; the remaining address bits are
  // deliberately ignored so the bank aliases across the BRAM window.
  logic [REG_IDX_W-1:0] word_idx;
  logic                 unused_addr;
  assign word_idx    = addr[ADDR_LSB +: REG_IDX_W];
  assign unused_addr = ^addr;

  // Synchronised asynchronous inputs
  logic [NUM_MOTORS-1:0] pfail_s;
  logic [NUM_MOTORS-1:0] sw_a_s;
  logic [NUM_MOTORS-1:0] sw_b_s;

  mcoi_sync_vector #(.WIDTH(NUM_MOTORS), .STAGES(SYNC_STAGES)) u_sync_pfail (
    .clk (clk),
    .rst (reset),
    .d   (pl_pfail),
    .q   (pfail_s)
  );

  mcoi_sync_vector #(.WIDTH(NUM_MOTORS), .STAGES(SYNC_STAGES)) u_sync_sw_a (
    .clk (clk),
    .rst (reset),
    .d   (pl_sw_outa),
    .q   (sw_a_s)
  );

  mcoi_sync_vector #(.WIDTH(NUM_MOTORS), .STAGES(SYNC_STAGES)) u_sync_sw_b (
    .clk (clk),
    .rst (reset),
    .d   (pl_sw_outb),
    .q   (sw_b_s)
  );

  // Register state
  logic [NUM_MOTORS-1:0] en_q,      en_d;
  logic [NUM_MOTORS-1:0] boost_q,   boost_d;
  logic [NUM_MOTORS-1:0] mask_q,    mask_d;
  logic [NUM_MOTORS-1:0] sticky_q,  sticky_d;
  logic [31:0]           scratch_q, scratch_d;
  logic [31:0]           dout_q,    dout_d;
  logic                  irq_q,     irq_d;

  logic [NUM_MOTORS-1:0] sticky_clr;
  logic [31:0]           rd_data;

  // Read mux over the pre-edge register values, which makes a same-cycle
  // read of a register being written return its old contents
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (word_idx)
      REG_ID:           rd_data = ID_VALUE;
      REG_EN:           rd_data = {16'h0, en_q};
      REG_BOOST:        rd_data = {16'h0, boost_q};
      REG_PFAIL:        rd_data = {16'h0, pfail_s};
      REG_PFAIL_STICKY: rd_data = {16'h0, sticky_q};
      REG_IRQ_MASK:     rd_data = {16'h0, mask_q};
      REG_SW_A:         rd_data = {16'h0, sw_a_s};
      REG_SW_B:         rd_data = {16'h0, sw_b_s};
      REG_SCRATCH:      rd_data = scratch_q;
      default:          rd_data = '0;
    endcase
  end

  // Byte-lane write decode, sticky capture and interrupt/readback next state
  always_comb begin
    en_d       = en_q;
    boost_d    = boost_q;
    mask_d     = mask_q;
    scratch_d  = scratch_q;
    sticky_clr = '0;

    if (en) begin
      case (word_idx)
        REG_EN:           en_d       = byte_merge16(en_q, din[15:0], we[1:0]);
        REG_BOOST:        boost_d    = byte_merge16(boost_q, din[15:0], we[1:0]);
        REG_IRQ_MASK:     mask_d     = byte_merge16(mask_q, din[15:0], we[1:0]);
        REG_PFAIL_STICKY: sticky_clr = w1c_mask16(din[15:0], we[1:0]);
        REG_SCRATCH:      scratch_d  = byte_merge32(scratch_q, din, we);
        default:          ;
      endcase
    end

    // A live fault always wins over a same-cycle software clear
    sticky_d = (sticky_q & ~sticky_clr) | pfail_s;

    irq_d = |(sticky_q & mask_q);

    // Port reset clears only the read data and overrides any read
    if (rst)     dout_d = '0;
    else if (en) dout_d = rd_data;
    else         dout_d = dout_q;
  end

  // Register bank state, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q      <= '0;
      boost_q   <= '0;
      mask_q    <= '0;
      sticky_q  <= '0;
      scratch_q <= '0;
      dout_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      boost_q   <= boost_d;
      mask_q    <= mask_d;
      sticky_q  <= sticky_d;
      scratch_q <= scratch_d;
      dout_q    <= dout_d;
      irq_q     <= irq_d;
    end
  end

  // A latched fault forces the motor off without touching the EN register
  assign motor_en    = en_q & ~sticky_q;
  assign motor_boost = boost_q;
  assign irq         = irq_q;
  assign dout        = dout_q;

endmodule

// File: tb/tb_mcoi_buffer_regbank.sv
// Self-checking bench for mcoi_buffer_regbank: directed scenarios followed by
// randomized register traffic against a word/byte-level reference model.
module tb_mcoi_buffer_regbank;
  import mcoi_buffer_regbank_pkg::*;

  localparam logic [31:0] ID = 32'h4D43_4F49;

  logic        clk;
  logic        tb_reset;
  ckrs_t       clk_rs;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] din;
  logic        rst;
  logic [31:0] dout;
  logic [15:0] pl_pfail;
  logic [15:0] pl_sw_outa;
  logic [15:0] pl_sw_outb;
  logic [15:0] motor_en;
  logic [15:0] motor_boost;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  assign clk_rs = '{clk: clk, reset: tb_reset};

  mcoi_buffer_regbank dut (
    .ClkRs_ix    (clk_rs),
    .en          (en),
    .we          (we),
    .addr        (addr),
    .din         (din),
    .rst         (rst),
    .dout        (dout),
    .pl_pfail    (pl_pfail),
    .pl_sw_outa  (pl_sw_outa),
    .pl_sw_outb  (pl_sw_outb),
    .motor_en    (motor_en),
    .motor_boost (motor_boost),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array of register words plus live status values
  logic [31:0] m_reg [64];
  logic [15:0] m_sw_a;
  logic [15:0] m_sw_b;

  function automatic logic [31:0] writable_bits(input logic [5:0] idx);
    case (idx)
      6'd1, 6'd2, 6'd5: return 32'h0000_FFFF;
      6'd8:             return 32'hFFFF_FFFF;
      default:          return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] idx);
    case (idx)
      6'd0:       return ID;
      6'd3, 6'd4: return 32'h0;   // no faults during random traffic
      6'd6:       return {16'h0, m_sw_a};
      6'd7:       return {16'h0, m_sw_b};
      default:    return m_reg[idx];
    endcase
  endfunction

  task automatic model_write(input logic [5:0] idx, input logic [31:0] data,
                             input logic [3:0] be);
    logic [31:0] bm;
    bm = '0;
    for (int i = 0; i < 4; i++) if (be[i]) bm[8*i +: 8] = 8'hFF;
    bm = bm & writable_bits(idx);
    m_reg[idx] = (m_reg[idx] & ~bm) | (data & bm);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] idx, input logic [31:0] data,
                           input logic [3:0] be);
    addr = {24'h0, idx, 2'b00};
    din  = data;
    we   = be;
    en   = 1'b1;
    tick();
    en   = 1'b0;
    we   = 4'h0;
  endtask

  task automatic bus_read(input logic [5:0] idx, output logic [31:0] data);
    addr = {24'h0, idx, 2'b00};
    we   = 4'h0;
    en   = 1'b1;
    tick();
    data = dout;
    en   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_dout;
    logic [31:0] last_dout;
    logic [5:0]  idx;
    logic [3:0]  be;
    logic [31:0] data;
    logic        act;

    tb_reset   = 1'b1;
    en         = 1'b0;
    we         = 4'h0;
    addr       = '0;
    din        = '0;
    rst        = 1'b0;
    pl_pfail   = '0;
    pl_sw_outa = '0;
    pl_sw_outb = '0;

    // Reset state
    repeat (3) tick();
    check("reset_dout",  dout, 32'h0);
    check("reset_men",   {16'h0, motor_en}, 32'h0);
    check("reset_boost", {16'h0, motor_boost}, 32'h0);
    check("reset_irq",   {31'h0, irq}, 32'h0);
    tb_reset = 1'b0;
    tick();

    // ID read with one-cycle latency
    addr = 32'h0;
    en   = 1'b1;
    #1;
    check("id_not_comb", dout, 32'h0);
    tick();
    check("id_read", dout, ID);
    en = 1'b0;

    // EN byte lanes
    bus_write(6'd1, 32'h0000_A5A5, 4'b0001);
    check("en_lane0", {16'h0, motor_en}, 32'h0000_00A5);
    bus_write(6'd1, 32'h0000_A5A5, 4'b0010);
    check("en_lane1", {16'h0, motor_en}, 32'h0000_A5A5);
    bus_read(6'd1, rd);
    check("en_readback", rd, 32'h0000_A5A5);
    bus_write(6'd2, 32'h0000_3C0F, 4'b0011);
    check("boost_out", {16'h0, motor_boost}, 32'h0000_3C0F);

    // Fault pulse on motor 3
    bus_write(6'd1, 32'h0000_FFFF, 4'b0011);
    bus_write(6'd5, 32'h0000_0008, 4'b0011);
    pl_pfail = 16'h0008;
    repeat (3) tick();
    bus_read(6'd3, rd);
    check("pfail_live", rd, 32'h0000_0008);
    check("pfail_men", {16'h0, motor_en}, 32'h0000_FFF7);
    check("pfail_irq", {31'h0, irq}, 32'h1);
    tick();
    pl_pfail = 16'h0;
    repeat (4) tick();
    bus_read(6'd3, rd);
    check("pfail_gone", rd, 32'h0);
    bus_read(6'd4, rd);
    check("sticky_held", rd, 32'h0000_0008);
    check("sticky_men", {16'h0, motor_en}, 32'h0000_FFF7);
    check("sticky_irq", {31'h0, irq}, 32'h1);
    bus_write(6'd4, 32'h0000_0008, 4'b0010);
    bus_read(6'd4, rd);
    check("w1c_wrong_lane", rd, 32'h0000_0008);
    bus_write(6'd4, 32'h0000_0008, 4'b0001);
    check("w1c_men", {16'h0, motor_en}, 32'h0000_FFFF);
    tick();
    check("w1c_irq", {31'h0, irq}, 32'h0);
    bus_read(6'd4, rd);
    check("w1c_sticky", rd, 32'h0);
    bus_read(6'd1, rd);
    check("en_untouched", rd, 32'h0000_FFFF);

    // Clear loses against a live fault
    pl_pfail = 16'h0001;
    repeat (3) tick();
    bus_write(6'd4, 32'h0000_0001, 4'b0001);
    bus_read(6'd4, rd);
    check("set_wins", rd, 32'h0000_0001);
    check("set_wins_men", {16'h0, motor_en}, 32'h0000_FFFE);
    pl_pfail = 16'h0;
    repeat (3) tick();
    bus_write(6'd4, 32'h0000_0001, 4'b0001);
    bus_read(6'd4, rd);
    check("clear_after", rd, 32'h0);

    // Read-first on same-address write
    bus_write(6'd8, 32'h1234_5678, 4'hF);
    addr = {24'h0, 6'd8, 2'b00};
    din  = 32'hCAFE_F00D;
    we   = 4'hF;
    en   = 1'b1;
    tick();
    check("rdw_old", dout, 32'h1234_5678);
    en = 1'b0;
    we = 4'h0;
    bus_read(6'd8, rd);
    check("rdw_new", rd, 32'hCAFE_F00D);

    // Boundaries: unused bits, RO, unmapped, hold, port reset
    bus_write(6'd2, 32'hFFFF_FFFF, 4'hF);
    bus_read(6'd2, rd);
    check("boost_upper", rd, 32'h0000_FFFF);
    bus_write(6'd0, 32'h0, 4'hF);
    bus_read(6'd0, rd);
    check("id_ro", rd, ID);
    bus_write(6'h3F, 32'hDEAD_BEEF, 4'hF);
    bus_read(6'h3F, rd);
    check("unmapped_3f", rd, 32'h0);
    bus_read(6'd8, rd);
    check("unmapped_no_alias", rd, 32'hCAFE_F00D);
    addr = 32'h0;
    tick();
    check("en0_hold", dout, 32'hCAFE_F00D);
    rst  = 1'b1;
    en   = 1'b1;
    tick();
    check("port_rst", dout, 32'h0);
    rst = 1'b0;
    en  = 1'b0;
    bus_read(6'd8, rd);
    check("port_rst_keeps", rd, 32'hCAFE_F00D);

    // Randomized traffic against the model
    m_sw_a     = 16'($urandom);
    m_sw_b     = 16'($urandom);
    pl_sw_outa = m_sw_a;
    pl_sw_outb = m_sw_b;
    foreach (m_reg[i]) m_reg[i] = '0;
    bus_write(6'd1, 32'h0, 4'hF);
    bus_write(6'd2, 32'h0, 4'hF);
    bus_write(6'd5, 32'h0, 4'hF);
    bus_write(6'd8, 32'h0, 4'hF);
    repeat (3) tick();
    bus_read(6'd0, rd);
    last_dout = ID;
    for (int k = 0; k < 80; k++) begin
      idx  = 6'($urandom_range(0, 11));
      if ($urandom_range(0, 7) == 0) idx = 6'h3F;
      be   = 4'($urandom);
      data = $urandom;
      act  = ($urandom_range(0, 3) != 0);
      addr = ($urandom & 32'hFFFF_FF00) | {24'h0, idx, 2'($urandom)};
      din  = data;
      we   = be;
      en   = act;
      exp_dout = act ? model_read(idx) : last_dout;
      if (act) model_write(idx, data, be);
      tick();
      check("rnd_dout",  dout, exp_dout);
      check("rnd_men",   {16'h0, motor_en}, {16'h0, m_reg[1][15:0]});
      check("rnd_boost", {16'h0, motor_boost}, {16'h0, m_reg[2][15:0]});
      check("rnd_irq",   {31'h0, irq}, 32'h0);
      last_dout = exp_dout;
    end
    en = 1'b0;
    we = 4'h0;

    // Asynchronous reset in the middle of an access
    bus_write(6'd1, 32'h0000_FFFF, 4'b0011);
    bus_write(6'd2, 32'h0000_00FF, 4'b0001);
    addr = {24'h0, 6'd1, 2'b00};
    en   = 1'b1;
    tick();
    #2;
    tb_reset = 1'b1;
    #1;
    check("async_men",   {16'h0, motor_en}, 32'h0);
    check("async_boost", {16'h0, motor_boost}, 32'h0);
    check("async_dout",  dout, 32'h0);
    #1;
    tb_reset = 1'b0;
    en = 1'b0;
    bus_read(6'd1, rd);
    check("after_rst_en", rd, 32'h0);
    bus_read(6'd8, rd);
    check("after_rst_scratch", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcoi_buffer_regbank.md
Name: mcoi_buffer_regbank

Overview:
- Memory-mapped register bank on the producer side of the `t_buffer` port (`dout`/`din`/`addr`/`we`).
- Serves the PS-side BRAM controller.
- Drives per-motor enable/boost levels for the 16 motor channels.
- Exposes synchronised, sticky-captured motor fault (`pl_pfail`) and end-switch (`pl_sw_outa`/`pl_sw_outb`) status to software.

Parameters:
- `ID_VALUE`, 32'h4D43_4F49, constant returned by the ID register.
- `SYNC_STAGES`, 2, flip-flop depth of the input synchronisers (legal range 2..4).
- `ADDR_LSB`, 2, lowest address bit used for word decode; the port is byte-addressed.

Ports:
- `ClkRs_ix.clk`  in  1  register clock (`ckrs_t` record).
- `ClkRs_ix.reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  port enable; a read or write occurs only when `en`=1.
- `we`  in  4  byte write enables, `we[i]` covers `din[8i+7:8i]`.
- `addr`  in  32  byte address; only `addr[ADDR_LSB+5:ADDR_LSB]` is decoded.
- `din`  in  32  write data.
- `rst`  in  1  buffer-port reset; synchronous clear of `dout` only.
- `dout`  out  32  registered read data.
- `pl_pfail`  in  16  motor power-fail, asynchronous, active-high.
- `pl_sw_outa`  in  16  end-switch A, asynchronous.
- `pl_sw_outb`  in  16  end-switch B, asynchronous.
- `motor_en`  out  16  per-motor enable level.
- `motor_boost`  out  16  per-motor boost level.
- `irq`  out  1  level, high while any unmasked sticky fault bit is set.

Behaviour:
- Register map (word index = `addr[7:2]`):
  - 0 ID: RO, returns `ID_VALUE`.
  - 1 EN: RW, bits[15:0] drive `motor_en`.
  - 2 BOOST: RW, bits[15:0] drive `motor_boost`.
  - 3 PFAIL: RO, live synchronised `pl_pfail`.
  - 4 PFAIL_STICKY: W1C, bits[15:0].
  - 5 IRQ_MASK: RW, bits[15:0]; 1 = enabled.
  - 6 SW_A: RO, live synchronised `pl_sw_outa`.
  - 7 SW_B: RO, live synchronised `pl_sw_outb`.
  - 8 SCRATCH: RW, full 32 bits.
- Unused bits of 16-bit registers read 0 and ignore writes.
- Unmapped reads return 0; unmapped writes are ignored without error.
- Reset (`ClkRs_ix.reset`=1, asynchronous):
  - `dout`=0, `motor_en`=0, `motor_boost`=0, `irq`=0.
  - All RW registers, sticky bits and synchroniser flops cleared.
- Read:
  - When `en`=1, `dout` is loaded on the next rising edge with the addressed value: 1-cycle latency.
  - When `en`=0, `dout` holds its value.
- Write:
  - When `en`=1, each byte with `we[i]`=1 is updated on the rising edge.
  - `we`=0 with `en`=1 is a pure read.
- Read-during-write to the same address: `dout` returns the old value (read-first).
- `rst`=1: `dout` cleared on the next edge and takes priority over a read; register contents are unaffected.
- Synchronisers:
  - `SYNC_STAGES` flops per input bit.
  - Status appears in the live registers `SYNC_STAGES` cycles after an input change.
- Sticky capture:
  - `sticky[i]` is set on any cycle where synchronised `pfail[i]`=1.
  - A write of 1 to `sticky[i]` clears it.
  - Same-cycle set and W1C clear on the same bit: set wins, so the bit stays 1.
  - A fault still active after a clear re-sets the bit on the next cycle.
- W1C honours byte enables: `we[0]` covers bits[7:0], `we[1]` covers bits[15:8].
- `irq`: registered; equals OR(sticky & mask); asserts one cycle after sticky/mask changes.
- Safety: `motor_en[i]` output = `EN[i]` AND NOT `sticky[i]`. The EN register contents are not modified; the motor re-enables once software clears the sticky bit.

Decomposition:
- Shared package (`constants`/`MCPkg`):
  - Register word-index localparams.
  - `NUM_MOTORS`=16.
  - `ID_VALUE` default.
  - `regbank_addr_t` enum of word indices.
- Sub-module `mcoi_sync_vector`: parametrised-width, `SYNC_STAGES`-deep synchroniser with async reset. It is instantiated three times (pfail, sw_a, sw_b).

Test Plan:
- Reset, then read ID at `addr` 0x00 with `en`=1 → `dout`=32'h4D43_4F49 exactly one cycle later; all outputs 0 during reset.
- Write EN=0x0000_A5A5 with `we`=4'b0001 → `motor_en`=16'h00A5. Write again with `we`=4'b0010 → `motor_en`=16'hA5A5. Read back → 0x0000_A5A5.
- Pulse `pl_pfail[3]` high for 5 cycles with EN=0xFFFF and IRQ_MASK=0x0008:
  - PFAIL reads 0x0008 during the pulse.
  - PFAIL_STICKY stays 0x0008 after the pulse.
  - `motor_en[3]`=0.
  - `irq`=1.
  - Write 0x0008 to PFAIL_STICKY → sticky=0, `motor_en[3]`=1, `irq`=0.
- Hold `pl_pfail[0]`=1 and write 0x0001 to PFAIL_STICKY in the same cycle a new set occurs → the sticky bit reads 1 afterwards.
- SCRATCH write 0x1234_5678, then in the same cycle read SCRATCH with `we`=4'hF, `din`=0xCAFE_F00D → `dout`=0x1234_5678; the next read returns 0xCAFE_F00D.
- Assert `ClkRs_ix.reset` mid-access with EN=0xFFFF → `motor_en`=0 immediately (asynchronous). Read of unmapped index 0x3F → `dout`=0. `rst`=1 concurrently with a read → `dout`=0.
